clock_enable_gen: RTL
=====================

Name: clock_enable_gen

Overview:
Parametrised, run-time programmable clock-enable generator with run/halt/single-step control for the CPU core.
- Replaces fixed toggle-only division with two outputs: a one-cycle tick enable for synchronous logic, and a square-wave clk_out for LEDs and probes.
- Adds a programmable divisor with glitch-free reload, a CPU halt input and a single-step button path.
- Sits between the board oscillator domain and the CPU/control-unit enables.

Parameters:
CNT_WIDTH, 32, width of divisor and period counter
DEFAULT_DIV, 50_000_000, divisor loaded at reset (tick period in clk_in cycles)
RUN_ON_RESET, 0, 1 = enter RUN after reset, 0 = enter HALT

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-low reset
div_val  input  CNT_WIDTH  new divisor value
div_load  input  1  one-cycle strobe; captures div_val
run  input  1  level; run request (synchronous to clk_in)
halt_req  input  1  one-cycle strobe from CPU HLT
step  input  1  debounced button level, asynchronous; rising edge requests one tick
tick  output  1  one-cycle clock enable
clk_out  output  1  square wave; toggles on every tick
running  output  1  high while in RUN
cur_div  output  CNT_WIDTH  divisor currently in effect

Behaviour:
- reset low, applied asynchronously:
  - counter = 0, div_reg = DEFAULT_DIV, no pending load.
  - tick = 0, clk_out = 0.
  - step synchroniser flops = 0, run_armed = 1.
  - state = RUN if RUN_ON_RESET else HALT.
- Divisor: a value of 0 on div_val is stored as 1. cur_div = div_reg.
- States: HALT, RUN, STEP.
- HALT:
  - counter held at 0; tick = 0; clk_out holds its level.
  - run = 1 and run_armed = 1 -> RUN.
  - Synchronised step rising edge -> STEP.
- RUN:
  - counter increments each cycle. When counter == div_reg-1, counter -> 0 and tick is registered high for the next cycle.
  - Tick period is exactly div_reg cycles. First tick arrives div_reg cycles after entering RUN. div_reg = 1 gives tick high every cycle.
  - run = 0 -> HALT next edge; counter cleared; no tick.
  - halt_req = 1 -> HALT next edge and run_armed = 0. run_armed returns to 1 only when run is sampled low, so a run level still held high does not restart.
  - halt_req on the terminal-count cycle: halt wins and that tick is suppressed.
  - step is ignored in RUN.
- STEP:
  - Lasts one cycle and emits exactly one tick, registered on the next edge.
  - Returns to HALT.
- Step path:
  - 2-flop synchroniser plus an edge register.
  - Tick goes high in the cycle after the 4th rising edge of clk_in at which step is sampled high, from HALT.
  - Holding step high produces one tick only.
- clk_out toggles in the same cycle that tick is high. In steady RUN its period is 2*div_reg.
- div_load:
  - In HALT: div_reg updates at the next edge.
  - In RUN: value goes to a shadow register and is applied at the next terminal count, so the current period always completes with the old divisor.
  - Several loads before that boundary: the last one wins.
  - div_load together with the terminal count: the shadow value is applied at that boundary.
- running = (state == RUN), registered.
- Reset asserted mid-period: all outputs go to reset values without waiting for a clock edge. No tick is emitted on release.
- Counter arithmetic is unsigned CNT_WIDTH and never exceeds div_reg-1.

Test Plan:
- Reset, RUN_ON_RESET = 0, DEFAULT_DIV = 4; run = 1 from cycle 0 -> first tick in cycle 4, then ticks every 4 cycles; clk_out 0 -> 1 -> 0 with period 8; running = 1.
- div_load with div_val = 2 while in RUN, mid-period at counter = 1 of div 4 -> next tick still 4 cycles after the previous one, then 2-cycle spacing; cur_div = 2 from that boundary. div_val = 0 -> cur_div = 1 and tick high every cycle.
- halt_req pulsed with run held at 1 -> no further ticks, running = 0; run 1 -> 0 -> 1 -> RUN resumes and first tick arrives div_reg cycles later.
- halt_req coincident with the terminal count -> no tick that cycle, clk_out unchanged, state HALT.
- In HALT, step held high for 20 cycles -> exactly one tick, 4 cycles after the first sampling edge; clk_out toggles once; step pulses during RUN -> no extra ticks.
- reset driven low asynchronously mid-period with div = 10, counter = 7 -> tick, clk_out, counter and running go to 0 immediately; cur_div returns to DEFAULT_DIV.

Source files
------------

// File: rtl/clock_enable_gen.sv
// Programmable clock-enable generator: one-cycle tick enable plus square-wave clk_out,
// with run/halt/single-step control and a glitch-free divisor reload.
module clock_enable_gen #(
  parameter int CNT_WIDTH    = 32,
  parameter int DEFAULT_DIV  = 50_000_000,
  parameter bit RUN_ON_RESET = 1'b0
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [CNT_WIDTH-1:0] div_val,
  input  logic                 div_load,
  input  logic                 run,
  input  logic                 halt_req,
  input  logic                 step,
  output logic                 tick,
  output logic                 clk_out,
  output logic                 running,
  output logic [CNT_WIDTH-1:0] cur_div,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] ST_HALT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_INIT = RUN_ON_RESET ? ST_RUN : ST_HALT;

  localparam logic [CNT_WIDTH-1:0] ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] DEF_RAW = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] DEF_DIV = (DEF_RAW == '0) ? ONE : DEF_RAW;

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_div;
  logic [CNT_WIDTH-1:0] r_shadow;
  logic                 r_pending;
  logic                 r_tick;
  logic                 r_clk_out;
  logic                 r_running;
  logic                 r_run_armed;
  logic                 r_step_s1;
  logic                 r_step_s2;
  logic                 r_step_d;

  logic [1:0]           w_state_nxt;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic                 w_tick_nxt;
  logic [CNT_WIDTH-1:0] w_div_nxt;
  logic [CNT_WIDTH-1:0] w_shadow_nxt;
  logic                 w_pending_nxt;
  logic [CNT_WIDTH-1:0] w_div_new;
  logic                 w_step_rise;
  logic                 w_terminal;

  // A zero divisor would never reach terminal count, so it is promoted to 1.
  assign w_div_new   = (div_val == '0) ? ONE : div_val;
  assign w_step_rise = r_step_s2 & ~r_step_d;
  assign w_terminal  = (r_count == (r_div - ONE));

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = '0;
    w_tick_nxt  = 1'b0;
    case (r_state)
      ST_HALT: begin
        if (run && r_run_armed) w_state_nxt = ST_RUN;
        else if (w_step_rise)   w_state_nxt = ST_STEP;
      end
      ST_RUN: begin
        // Leaving RUN takes priority over a terminal-count tick.
        if (!run || halt_req) w_state_nxt = ST_HALT;
        else if (w_terminal)  w_tick_nxt  = 1'b1;
        else                  w_count_nxt = r_count + ONE;
      end
      ST_STEP: begin
        w_state_nxt = ST_HALT;
        w_tick_nxt  = 1'b1;
      end
      default: w_state_nxt = ST_HALT;
    endcase
  end

  always_comb begin
    w_div_nxt     = r_div;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    if (r_state == ST_RUN) begin
      if (div_load) begin
        w_shadow_nxt  = w_div_new;
        w_pending_nxt = 1'b1;
      end
      // Divisor only changes at a period boundary, so the running period finishes intact.
      if (w_tick_nxt) begin
        if (div_load)       w_div_nxt = w_div_new;
        else if (r_pending) w_div_nxt = r_shadow;
        w_pending_nxt = 1'b0;
      end
    end else begin
      if (div_load)       w_div_nxt = w_div_new;
      else if (r_pending) w_div_nxt = r_shadow;
      w_pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_INIT;
      r_count     <= '0;
      r_div       <= DEF_DIV;
      r_shadow    <= DEF_DIV;
      r_pending   <= 1'b0;
      r_tick      <= 1'b0;
      r_clk_out   <= 1'b0;
      r_running   <= RUN_ON_RESET;
      r_run_armed <= 1'b1;
      r_step_s1   <= 1'b0;
      r_step_s2   <= 1'b0;
      r_step_d    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_div     <= w_div_nxt;
      r_shadow  <= w_shadow_nxt;
      r_pending <= w_pending_nxt;
      r_tick    <= w_tick_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      if (w_tick_nxt) r_clk_out <= ~r_clk_out;
      // A halt disarms RUN until run is seen low, so a held run level cannot restart.
      if ((r_state == ST_RUN) && halt_req) r_run_armed <= 1'b0;
      else if (!run)                       r_run_armed <= 1'b1;
      r_step_s1 <= step;
      r_step_s2 <= r_step_s1;
      r_step_d  <= r_step_s2;
    end
  end

  assign tick      = r_tick;
  assign clk_out   = r_clk_out;
  assign running   = r_running;
  assign cur_div   = r_div;
  assign dbg_state = r_state;

endmodule
